core_dmem_port: RTL
===================

Name: core_dmem_port

Overview:
- Core-side initiator for the shared data-memory arbiter (dmem_controller); the requester end of the memREAD/memWE/AR/DR/memAV/MEM handshake.
- Accepts one load/store at a time from the core datapath, holds the request on the arbiter bus until granted, and waits out read latency.
- Returns a single-cycle response pulse with the captured read data.
- One instance per core, between the core execute stage and dmem_controller.

Parameters:
- WIDTH, 8, data and address width.
- READ_LAT, 1, cycles from the memAV grant cycle to MEM valid (range 1..3).
- TIMEOUT, 255, grant-wait cycles before abort (used only with CDP_TIMEOUT_EN).

Ports:
- Clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core requests a memory access.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  WIDTH  absolute DRAM address.
- req_wdata  in  WIDTH  store data.
- req_ready  out  1  port idle; request accepted when req_valid && req_ready.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  WIDTH  load data, valid with rsp_valid; holds its value otherwise.
- rsp_err  out  1  timeout abort flag, valid with rsp_valid.
- memREAD  out  1  read request to arbiter.
- memWE  out  1  write request to arbiter.
- AR  out  WIDTH  address to arbiter.
- DR  out  WIDTH  write data to arbiter.
- memAV  in  1  arbiter grant, one-cycle pulse.
- MEM  in  WIDTH  read data from arbiter.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async on rst_n low, sync release):
  - state = IDLE.
  - All outputs 0 except req_ready = 1.
  - Counters 0.
- Reset mid-transaction: the request is dropped, memREAD/memWE deassert immediately, and no rsp_valid is issued.
- States: IDLE, REQ, RWAIT.
- IDLE:
  - req_ready = 1.
  - On accept, register addr, wdata and we into AR, DR and an internal we flag, then go to REQ.
  - memREAD = !we and memWE = we are driven from the registered flag starting the next cycle.
- REQ:
  - memREAD or memWE held high; AR and DR stable until grant.
  - memAV == 1 and store: the write commits that cycle. Next cycle: memWE = 0, rsp_valid = 1, state IDLE.
  - memAV == 1 and load: drop memREAD the next cycle, load lat_cnt = READ_LAT - 1, go to RWAIT.
  - memAV == 0: stay in REQ.
- RWAIT:
  - lat_cnt decrements each cycle.
  - At lat_cnt == 0: rsp_rdata <= MEM, rsp_valid = 1 the following cycle, state IDLE.
  - Net result: with READ_LAT = 1, MEM is sampled in the cycle after memAV.
- Latency:
  - Store: grant cycle + 1 cycle to rsp_valid.
  - Load: grant cycle + READ_LAT + 1 cycles.
  - Minimum load, granted the same cycle the request first appears: 3 cycles from accept.
- Back-to-back: the cycle rsp_valid is high, state is already IDLE and req_ready = 1, so a new request may be accepted in the same cycle.
- Only one outstanding request. req_valid while req_ready = 0 is ignored; the core must hold it.
- memAV seen while in IDLE or RWAIT is ignored (spurious grant).
- memREAD and memWE are never both high.

Optional Feature:
- CDP_TIMEOUT_EN defined:
  - An 8-bit wait counter increments each REQ cycle without memAV.
  - At count == TIMEOUT the request is deasserted and the block returns to IDLE.
  - The abort response pulses rsp_valid = 1 with rsp_err = 1 and rsp_rdata = 0.
  - The counter clears on grant or on accept.
- CDP_TIMEOUT_EN undefined:
  - The block waits indefinitely in REQ.
  - rsp_err is tied to 0 and no counter is synthesised.

Decomposition:
- Shared package cdp_pkg holds the state encoding constants (IDLE = 2'd0, REQ = 2'd1, RWAIT = 2'd2) and the default TIMEOUT value.
- Natural sub-module: cdp_lat_counter, a loadable down-counter with a zero flag, reused for read latency and the timeout.

Test Plan:
1. Store, immediate grant:
   - Stimulus: req_we = 1, addr = 8'h80, wdata = 8'h5A; memAV the first cycle memWE is high.
   - Required: one write with AR = 80, DR = 5A; rsp_valid 1 cycle later; rsp_err = 0.
2. Load, delayed grant:
   - Stimulus: load addr = 8'h9F; memAV after 4 cycles; MEM = 8'hC3 the following cycle (READ_LAT = 1).
   - Required: rsp_rdata = C3; memREAD high for exactly 5 cycles.
3. Back-to-back:
   - Stimulus: store, then a load accepted on the rsp_valid cycle.
   - Required: second memREAD rises the next cycle; no idle gap.
4. READ_LAT = 3:
   - Stimulus: MEM valid 3 cycles after memAV with 8'h11; garbage 8'hEE in between.
   - Required: rsp_rdata = 11.
5. Reset mid-REQ:
   - Stimulus: rst_n low while memREAD = 1.
   - Required: memREAD = 0 asynchronously; no rsp_valid after release; req_ready = 1.
6. CDP_TIMEOUT_EN, TIMEOUT = 10, memAV never asserted:
   - Required: rsp_valid and rsp_err high after 10 REQ cycles; rsp_rdata = 0; memREAD low.

Source files
------------

// File: rtl/cdp_pkg.sv
// Shared definitions for the core-side data-memory port: FSM state encoding
// and parameter defaults used by core_dmem_port and its latency/timeout counters.
package cdp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RWAIT = 2'd2
   } cdp_state_e;

   localparam int CDP_TIMEOUT_DEFAULT = 255;
   localparam int CDP_TO_W            = 8;
   localparam int CDP_LAT_W           = 2;

endpackage

// File: rtl/cdp_lat_counter.sv
// Loadable down-counter with zero flag; stops at zero rather than wrapping.
// Used for read-latency wait and for the grant-wait timeout.
module cdp_lat_counter #(
   parameter int W = 2
) (
   input  logic         Clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/core_dmem_port.sv
// Core-side requester for dmem_controller: one load/store outstanding, held until memAV.
// Optional grant-wait abort is built when CDP_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | ready for a new request, req_ready = 1
// REQ   | memREAD or memWE held, AR/DR stable, waiting for memAV
// RWAIT | load granted, counting down read latency before sampling MEM
module core_dmem_port
   import cdp_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int READ_LAT = 1,
   parameter int TIMEOUT  = CDP_TIMEOUT_DEFAULT
) (
   input  logic             Clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic             req_we,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             req_ready,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic             memREAD,
   output logic             memWE,
   output logic [WIDTH-1:0] AR,
   output logic [WIDTH-1:0] DR,
   input  logic             memAV,
   input  logic [WIDTH-1:0] MEM,
   output logic             busy
);

   if (READ_LAT < 1 || READ_LAT > 3 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
      $error("core_dmem_port: READ_LAT must be 1..3 and TIMEOUT 1..255");
   end

   localparam logic [CDP_LAT_W-1:0] LAT_LOAD = CDP_LAT_W'(READ_LAT - 1);

   cdp_state_e       state, state_nxt;
   logic             we_q;
   logic [WIDTH-1:0] ar_q, dr_q, rdata_q;
   logic             rsp_valid_q;
   logic             accept, grant, lat_zero, lat_done, abort;

   assign accept   = req_valid && (state == IDLE);
   assign grant    = memAV && (state == REQ);
   assign lat_done = lat_zero && (state == RWAIT);

   cdp_lat_counter #(.W(CDP_LAT_W)) u_lat_cnt (
      .Clk      (Clk),
      .rst_n    (rst_n),
      .load     (grant && !we_q),
      .load_val (LAT_LOAD),
      .dec      (state == RWAIT),
      .zero     (lat_zero)
   );

`ifdef CDP_TIMEOUT_EN
   localparam logic [CDP_TO_W-1:0] TO_LOAD = CDP_TO_W'(TIMEOUT - 1);

   logic to_zero;
   logic rsp_err_q;

   // Reloaded on every accept; counts down only through ungranted REQ cycles.
   cdp_lat_counter #(.W(CDP_TO_W)) u_to_cnt (
      .Clk      (Clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (TO_LOAD),
      .dec      ((state == REQ) && !memAV),
      .zero     (to_zero)
   );

   assign abort = (state == REQ) && !memAV && to_zero;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err_q <= 1'b0;
      end else begin
         rsp_err_q <= abort;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign abort   = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = REQ;
         end
         REQ: begin
            if (memAV)      state_nxt = we_q ? IDLE : RWAIT;
            else if (abort) state_nxt = IDLE;
         end
         RWAIT: begin
            if (lat_zero) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      busy      = (state != IDLE);
      memREAD   = (state == REQ) && !we_q;
      memWE     = (state == REQ) && we_q;
   end

   // Response pulse lands in the cycle the FSM is back in IDLE, allowing back-to-back accept.
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q        <= 1'b0;
         ar_q        <= '0;
         dr_q        <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            we_q <= req_we;
            ar_q <= req_addr;
            dr_q <= req_wdata;
         end
         rsp_valid_q <= (grant && we_q) || lat_done || abort;
         if (lat_done) begin
            rdata_q <= MEM;
         end else if (abort) begin
            rdata_q <= '0;
         end
      end
   end

   assign AR        = ar_q;
   assign DR        = dr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;

endmodule
